// File: rtl/dtw_result_packer.sv
// dtw_result_packer: reads 3-word DTW results from a FWFT FIFO, thresholds the score
// and streams a 4-beat record (qid, position, minval word, flags) on AXI-Stream.
module dtw_result_packer #(
   parameter int WIDTH      = 16,
   parameter int AXIS_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [WIDTH-1:0]      cfg_threshold,
   input  logic                  cfg_drop_miss,
   input  logic                  cnt_clear,
   input  logic                  res_fifo_empty,
   input  logic [AXIS_WIDTH-1:0] res_fifo_data,
   output logic                  res_fifo_rden,
   output logic [AXIS_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic                  busy,
   output logic [31:0]           rec_count,
   output logic [31:0]           hit_count,
   output logic [31:0]           drop_count
);
   localparam logic [3:0] IDLE   = 4'd0;
   localparam logic [3:0] RD_QID = 4'd1;
   localparam logic [3:0] RD_POS = 4'd2;
   localparam logic [3:0] RD_MIN = 4'd3;
   localparam logic [3:0] EVAL   = 4'd4;
   localparam logic [3:0] OUT0   = 4'd5;
   localparam logic [3:0] OUT1   = 4'd6;
   localparam logic [3:0] OUT2   = 4'd7;
   localparam logic [3:0] OUT3   = 4'd8;

   logic [3:0]            state_q, state_d;
   logic [AXIS_WIDTH-1:0] qid_q, qid_d, pos_q, pos_d, min_q, min_d;
   logic                  hit_q, hit_d, fmt_q, fmt_d;
   logic [31:0]           rec_q, rec_d, hitc_q, hitc_d, drop_q, drop_d;
   logic                  hit_now;

   always_comb begin
      res_fifo_rden = (state_q == RD_QID || state_q == RD_POS || state_q == RD_MIN) && !res_fifo_empty;
      m_axis_tvalid = state_q == OUT0 || state_q == OUT1 || state_q == OUT2 || state_q == OUT3;
      m_axis_tlast  = state_q == OUT3;
      busy          = state_q != IDLE;
      m_axis_tdata  = state_q == OUT0 ? qid_q :
                      state_q == OUT1 ? pos_q :
                      state_q == OUT2 ? min_q :
                      state_q == OUT3 ? {{(AXIS_WIDTH-2){1'b0}}, fmt_q, hit_q} : '0;
      hit_now       = min_q[WIDTH-1:0] <= cfg_threshold;
   end

   always_comb begin
      state_d = state_q;
      qid_d   = qid_q;
      pos_d   = pos_q;
      min_d   = min_q;
      hit_d   = hit_q;
      fmt_d   = fmt_q;
      rec_d   = rec_q;
      hitc_d  = hitc_q;
      drop_d  = drop_q;
      case (state_q)
         IDLE:   if (en) state_d = RD_QID;
         RD_QID: if (res_fifo_rden) begin qid_d = res_fifo_data; state_d = RD_POS; end
         RD_POS: if (res_fifo_rden) begin pos_d = res_fifo_data; state_d = RD_MIN; end
         RD_MIN: if (res_fifo_rden) begin min_d = res_fifo_data; state_d = EVAL; end
         EVAL: begin
            hit_d  = hit_now;
            fmt_d  = (min_q >> WIDTH) != '0;
            rec_d  = rec_q + 32'd1;
            hitc_d = hitc_q + {31'd0, hit_now};
            if (!hit_now && cfg_drop_miss) begin
               drop_d  = drop_q + 32'd1;
               state_d = IDLE;
            end else begin
               state_d = OUT0;
            end
         end
         OUT0, OUT1, OUT2: if (m_axis_tready) state_d = state_q + 4'd1;
         OUT3:   if (m_axis_tready) state_d = en ? RD_QID : IDLE;
         default: state_d = IDLE;
      endcase
      // a clear coinciding with an EVAL increment must leave the counters at zero
      if (cnt_clear) begin
         rec_d  = '0;
         hitc_d = '0;
         drop_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         qid_q   <= '0;
         pos_q   <= '0;
         min_q   <= '0;
         hit_q   <= 1'b0;
         fmt_q   <= 1'b0;
         rec_q   <= '0;
         hitc_q  <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         qid_q   <= qid_d;
         pos_q   <= pos_d;
         min_q   <= min_d;
         hit_q   <= hit_d;
         fmt_q   <= fmt_d;
         rec_q   <= rec_d;
         hitc_q  <= hitc_d;
         drop_q  <= drop_d;
      end
   end

   assign rec_count  = rec_q;
   assign hit_count  = hitc_q;
   assign drop_count = drop_q;
endmodule

// File: tb/tb_dtw_result_packer.sv
// tb_dtw_result_packer: FIFO model + scoreboard bench; records are turned into expected
// beats and counter totals when queued, a monitor compares every accepted beat.
module tb_dtw_result_packer;
   localparam int LIM = 20000;
   logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, cfg_drop_miss = 1'b0, cnt_clear = 1'b0;
   logic [15:0] cfg_threshold = '0;
   logic        res_fifo_empty = 1'b1, res_fifo_rden;
   logic [31:0] res_fifo_data = '0, m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b0, busy;
   logic [31:0] rec_count, hit_count, drop_count;
   logic [31:0] fq[$], pend[$];
   logic [32:0] exp_q[$];
   logic [31:0] m_rec = '0, m_hit = '0, m_drop = '0;
   int          n_tests = 0, n_fail = 0, stall_pct = 0;
   bit          rnd_rdy = 1'b0;

   always #5 clk = ~clk;

   dtw_result_packer dut (
      .clk(clk), .rst_n(rst_n), .en(en), .cfg_threshold(cfg_threshold),
      .cfg_drop_miss(cfg_drop_miss), .cnt_clear(cnt_clear),
      .res_fifo_empty(res_fifo_empty), .res_fifo_data(res_fifo_data), .res_fifo_rden(res_fifo_rden),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
      .m_axis_tready(m_axis_tready), .busy(busy),
      .rec_count(rec_count), .hit_count(hit_count), .drop_count(drop_count)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic send_rec(input logic [31:0] q, input logic [31:0] p, input logic [31:0] mw, input bit hold = 1'b0);
      logic h, f;
      h = mw[15:0] <= cfg_threshold;
      f = mw[31:16] != 16'd0;
      fq.push_back(q);
      if (hold) begin
         pend.push_back(p);
         pend.push_back(mw);
      end else begin
         fq.push_back(p);
         fq.push_back(mw);
      end
      m_rec = m_rec + 32'd1;
      if (h) m_hit = m_hit + 32'd1;
      if (!h && cfg_drop_miss) m_drop = m_drop + 32'd1;
      else begin
         exp_q.push_back({1'b0, q});
         exp_q.push_back({1'b0, p});
         exp_q.push_back({1'b0, mw});
         exp_q.push_back({1'b1, 30'd0, f, h});
      end
   endtask

   task automatic run_phase(input string nm);
      int n;
      n = 0;
      en = 1'b1;
      while (fq.size() != 0 && n < LIM) begin @(negedge clk); n++; end
      en = 1'b0;
      while ((busy || exp_q.size() != 0) && n < LIM) begin @(negedge clk); n++; end
      chk({nm, "_done_in_time"}, n < LIM, 1);
      chk({nm, "_rec_count"}, rec_count, m_rec);
      chk({nm, "_hit_count"}, hit_count, m_hit);
      chk({nm, "_drop_count"}, drop_count, m_drop);
      chk({nm, "_beats_left"}, exp_q.size(), 0);
   endtask

   task automatic wait_valid(input string nm);
      int n;
      n = 0;
      while (!m_axis_tvalid && n < LIM) begin @(negedge clk); n++; end
      chk({nm, "_valid_in_time"}, n < LIM, 1);
   endtask

   // FWFT FIFO model: pops are seen at the edge, the head is updated on the falling edge
   initial begin
      bit pop;
      forever begin
         @(posedge clk);
         pop = res_fifo_rden;
         @(negedge clk);
         if (pop && fq.size() != 0) fq.delete(0);
         res_fifo_empty = fq.size() == 0 || $urandom_range(0, 99) < stall_pct;
         res_fifo_data  = fq.size() != 0 ? fq[0] : 32'd0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (rnd_rdy) m_axis_tready = $urandom_range(0, 99) < 70;
   end

   initial begin
      logic        held;
      logic [31:0] hd;
      logic        hl;
      logic [32:0] e;
      held = 1'b0;
      hd = '0;
      hl = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) held = 1'b0;
         else begin
            if (busy && res_fifo_empty) chk("rden_while_empty", res_fifo_rden, 0);
            if (held) begin
               chk("stall_valid", m_axis_tvalid, 1);
               chk("stall_data", m_axis_tdata, hd);
               chk("stall_last", m_axis_tlast, hl);
            end
            if (m_axis_tvalid && m_axis_tready) begin
               chk("beat_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("beat_data", m_axis_tdata, e[31:0]);
                  chk("beat_last", m_axis_tlast, e[32]);
               end
            end
            held = m_axis_tvalid && !m_axis_tready;
            hd = m_axis_tdata;
            hl = m_axis_tlast;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d tests, %0d failed", n_tests, n_fail);
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_rden", res_fifo_rden, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_rec", rec_count, 0);
      chk("rst_hit", hit_count, 0);
      chk("rst_drop", drop_count, 0);
      rst_n = 1'b1;
      @(negedge clk);
      m_axis_tready = 1'b1;
      cfg_threshold = 16'd100;
      cfg_drop_miss = 1'b0;
      send_rec(32'd7, 32'd1234, 32'd50);
      run_phase("hit");
      cfg_drop_miss = 1'b1;
      send_rec(32'd9, 32'd99, 32'd200);
      run_phase("drop");
      chk("drop_idle", busy, 0);
      cfg_drop_miss = 1'b0;
      cfg_threshold = 16'd4;
      send_rec(32'd3, 32'd4, 32'h0001_0005);
      run_phase("fmt_err");
      // backpressure in OUT1
      cfg_threshold = 16'd100;
      m_axis_tready = 1'b0;
      send_rec(32'd21, 32'd4321, 32'd60);
      en = 1'b1;
      wait_valid("bp");
      en = 1'b0;
      m_axis_tready = 1'b1;
      @(negedge clk);
      m_axis_tready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_hold_pos", m_axis_tdata, 32'd4321);
      end
      m_axis_tready = 1'b1;
      run_phase("backpressure");
      // FIFO starved between qid and position
      send_rec(32'd11, 32'd22, 32'd33, 1'b1);
      en = 1'b1;
      for (int n = 0; n < 100 && fq.size() != 0; n++) @(negedge clk);
      repeat (3) begin
         @(negedge clk);
         chk("starve_rden", res_fifo_rden, 0);
         chk("starve_busy", busy, 1);
      end
      while (pend.size() != 0) fq.push_back(pend.pop_front());
      run_phase("starve");
      // reset while presenting the minval beat
      m_axis_tready = 1'b0;
      cfg_threshold = 16'd500;
      send_rec(32'hAAAA, 32'hBBBB, 32'd10);
      en = 1'b1;
      wait_valid("rst_mid");
      en = 1'b0;
      m_axis_tready = 1'b1;
      repeat (2) @(negedge clk);
      chk("pre_rst_out2_data", m_axis_tdata, 32'd10);
      m_axis_tready = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      fq.delete();
      #1;
      chk("mid_rst_tvalid", m_axis_tvalid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_tdata", m_axis_tdata, 0);
      chk("mid_rst_rec", rec_count, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_rec = '0;
      m_hit = '0;
      m_drop = '0;
      m_axis_tready = 1'b1;
      send_rec(32'h1357, 32'h2468, 32'd499);
      run_phase("after_rst");
      // randomized traffic with backpressure and FIFO stalls
      rnd_rdy = 1'b1;
      stall_pct = 30;
      for (int ph = 0; ph < 4; ph++) begin
         cfg_threshold = 16'($urandom_range(0, 1000));
         cfg_drop_miss = 1'($urandom_range(0, 1));
         for (int r = 0; r < 12; r++) begin
            logic [15:0] hi;
            hi = $urandom_range(0, 7) == 0 ? 16'($urandom_range(1, 65535)) : 16'd0;
            send_rec($urandom, $urandom, {hi, 16'($urandom_range(0, 1000))});
         end
         run_phase("random");
      end
      // clear held across whole records, including their EVAL cycles
      cnt_clear = 1'b1;
      for (int r = 0; r < 3; r++) send_rec($urandom, $urandom, 32'($urandom_range(0, 1000)));
      m_rec = '0;
      m_hit = '0;
      m_drop = '0;
      run_phase("clear");
      cnt_clear = 1'b0;
      send_rec(32'd5, 32'd6, 32'd0);
      run_phase("post_clear");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/dtw_result_packer.md
DTW_RESULT_PACKER -- requirements
Module: dtw_result_packer

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the DTW score width (minval field).
REQ-002 Parameter AXIS_WIDTH, default 32, SHALL set the result-word and output-stream data width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 en  input  1  SHALL enable the start of new records when high.
REQ-006 cfg_threshold  input  WIDTH  SHALL be the match threshold; a record hits when minval <= cfg_threshold.
REQ-007 cfg_drop_miss  input  1  SHALL select miss handling: 1 discards missed records, 0 forwards them.
REQ-008 cnt_clear  input  1  SHALL synchronously zero all counters.
REQ-009 res_fifo_empty  input  1  SHALL be the result FIFO empty flag.
REQ-010 res_fifo_data  input  AXIS_WIDTH  SHALL be the first-word-fall-through head word, valid while empty=0.
REQ-011 res_fifo_rden  output  1  SHALL pop the head word from the FIFO.
REQ-012 m_axis_tdata, m_axis_tvalid, m_axis_tlast  output  AXIS_WIDTH/1/1  SHALL form the AXI-Stream master.
REQ-013 m_axis_tready  input  1  SHALL be the AXI-Stream ready.
REQ-014 busy  output  1  SHALL be high in every state except IDLE.
REQ-015 rec_count, hit_count, drop_count  output  32 each  SHALL count evaluated, hit and dropped records.

Function
REQ-016 Input record SHALL be three FIFO words in order: qid, position, {16'b0, minval}.
REQ-017 States SHALL be IDLE, RD_QID, RD_POS, RD_MIN, EVAL, OUT0, OUT1, OUT2, OUT3.
REQ-018 IDLE SHALL go to RD_QID when en=1.
REQ-019 In each RD_* state, res_fifo_rden SHALL be combinational (state==RD_*) & !res_fifo_empty.
REQ-020 On a popping edge, each RD_* state SHALL capture res_fifo_data into its field register and advance; otherwise it SHALL hold.
REQ-021 If en falls, the block SHALL finish the current record, then remain in IDLE.
REQ-022 EVAL SHALL last exactly one cycle and compute hit = (minval[WIDTH-1:0] <= cfg_threshold), unsigned.
REQ-023 EVAL SHALL set fmt_err = 1 when the upper AXIS_WIDTH-WIDTH bits of the minval word are nonzero.
REQ-024 EVAL SHALL increment rec_count and, if hit, increment hit_count.
REQ-025 If hit=0 and cfg_drop_miss=1, EVAL SHALL increment drop_count and go to IDLE with no output.
REQ-026 Otherwise EVAL SHALL go to OUT0; m_axis_tvalid SHALL rise in the cycle after EVAL.
REQ-027 OUT0..OUT3 SHALL present qid, position, {zeros, minval}, {30'b0, fmt_err, hit} respectively.
REQ-028 m_axis_tlast SHALL be high only in OUT3.
REQ-029 Each OUTn SHALL advance only on tvalid & tready; tdata, tlast and tvalid SHALL remain stable while tready=0.
REQ-030 OUT3 SHALL go to RD_QID if en=1, else to IDLE; back-to-back records SHALL need no idle cycle.
REQ-031 m_axis_tvalid SHALL be low in all non-OUT states.
REQ-032 Counters SHALL wrap modulo 2^32.
REQ-033 If cnt_clear coincides with an EVAL increment, the counters SHALL read 0 after the edge (clear wins).
REQ-034 cfg_threshold and cfg_drop_miss SHALL be sampled in EVAL only.

Reset
REQ-035 rst_n=0 SHALL immediately force state IDLE; tvalid, tlast, rden and busy SHALL go 0, and tdata, field registers and counters SHALL go 0.
REQ-036 A reset mid-record SHALL discard the partial record; no resync to a record boundary SHALL be attempted.

Verification
REQ-037 Hit record: threshold=100, FIFO words 7, 1234, 50, tready=1 -> stream 7, 1234, 50, 1 with tlast on the 4th beat; rec_count=1, hit_count=1.
REQ-038 Dropped miss: drop_miss=1, minval=200, threshold=100 -> no tvalid; drop_count=1, state back in IDLE.
REQ-039 Forwarded miss with format error: drop_miss=0, minval word 0x0001_0005 -> flag word 0x2, and tdata on the minval beat is 0x0001_0005.
REQ-040 Backpressure: tready low for 5 cycles in OUT1 -> tdata=position is held stable; still exactly 4 beats are produced.
REQ-041 Starved FIFO: empty=1 for 3 cycles between qid and position -> rden stays 0 and the stream content is unchanged.
REQ-042 Reset asserted in OUT2, then a new record -> tvalid=0 at once, counters 0, and the new record is emitted correctly from OUT0.
